uart_tx_buffered: RTL
=====================

Name: uart_tx_buffered

Overview:
Single-clock UART transmitter with an integrated baud divider and a parametrised write FIFO. It replaces the separate clock-divider plus depth-1 TX FIFO pairing with one block clocked directly from the 50 MHz board clock. It adds configurable data width, FIFO depth, parity and stop bits, plus back-pressure (FULL), occupancy reporting, overflow flagging and a transmit-enable gate. It sits between the scoreboard control logic and the RS-232 TX pin.

Parameters:
DATA_W, 8, data bits per frame (5..9)
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 words (1..8)
CLK_DIV, 434, CLK cycles per bit (>=2; 434 gives ~115200 baud at 50 MHz)
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
CLK  in  1  system clock, 50 MHz, all logic on rising edge
RST  in  1  asynchronous, active-low reset
WR_EN  in  1  write strobe, one word per cycle while high
DATA  in  DATA_W  word to enqueue, sampled when WR_EN=1
TX_EN  in  1  1 = frames may start; 0 = finish current frame, then hold line idle
TX  out  1  serial line, idle high
FULL  out  1  FIFO holds 2**DEPTH_LOG2 words
EMPTY  out  1  FIFO holds 0 words
COUNT  out  DEPTH_LOG2+1  FIFO occupancy, 0..2**DEPTH_LOG2
BUSY  out  1  frame in progress (FSM not IDLE)
OVERFLOW  out  1  one-cycle pulse when a write is rejected

Behaviour:
- Reset (RST=0, async): TX=1, FULL=0, EMPTY=1, COUNT=0, BUSY=0, OVERFLOW=0, FSM=IDLE, baud counter=0, FIFO pointers=0. Stored words are discarded. Reset mid-frame aborts the frame and TX goes high immediately.
- Write: accepted when WR_EN=1 and registered FULL=0. When WR_EN=1 and FULL=1, the word is dropped and OVERFLOW=1 for the following cycle. A pop in the same cycle does not rescue the write.
- Simultaneous accepted write and pop: COUNT unchanged, both pointers advance. Pointers wrap modulo depth. COUNT is kept as a separate register.
- FSM states: IDLE, START, DATA, PARITY (skipped when PARITY=0), STOP.
- IDLE: if EMPTY=0 and TX_EN=1, pop the head word into the shift register, set TX=0, go to START, and clear the baud counter. A word written at edge k into an empty FIFO with the FSM idle drives TX low at edge k+1.
- Baud counter runs 0..CLK_DIV-1. A bit ends when the counter reaches CLK_DIV-1; each bit therefore lasts exactly CLK_DIV cycles.
- Bit sequence:
  - START: TX=0.
  - DATA: DATA_W bits, LSB first.
  - PARITY: even = XOR of the data bits; odd = its inverse.
  - STOP: TX=1 for STOP_BITS bit times.
- Frame length = CLK_DIV*(1+DATA_W+(PARITY!=0)+STOP_BITS) cycles.
- End of last stop bit:
  - If EMPTY=0 and TX_EN=1, pop and start the next frame on the same edge (no idle gap).
  - Otherwise go to IDLE.
- TX_EN is sampled only in IDLE and at the end of a frame; deasserting it never truncates a frame.
- BUSY=1 in every state except IDLE. TX is registered and glitch-free.

Decomposition:
- Package uart_pkg:
  - PARITY_NONE/EVEN/ODD constants.
  - FSM state encoding.
  - Function frame_bits(DATA_W, PARITY, STOP_BITS).
- Sub-module uart_sync_fifo (parameters DATA_W, DEPTH_LOG2) holds storage, pointers, COUNT, FULL, EMPTY and OVERFLOW.
- The top level holds the baud counter, shift register, bit counter and FSM.

Test Plan:
1. CLK_DIV=4, 8N1, single write of 0x55 → TX low 4 cycles starting 1 cycle after write, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles. BUSY high for exactly 40 cycles.
2. PARITY=1 with 0x86, then PARITY=2 with 0x86 → parity bit 1 (even), then 0 (odd). Frame 44 cycles each.
3. DEPTH_LOG2=4, TX_EN=0, 17 consecutive writes → FULL=1 after the 16th, COUNT=16, OVERFLOW pulses one cycle after the 17th, TX stays 1. Set TX_EN=1 → 16 frames are sent in write order.
4. Four back-to-back writes (0x86, 0x8C, 0x8D, 0x9A), CLK_DIV=4, 8N1 → 160 contiguous frame cycles with no idle gap. BUSY falls at cycle 161, EMPTY=1.
5. RST low at the 3rd data bit with 2 words queued → TX=1, COUNT=0, BUSY=0 immediately. After release, no frame starts.
6. STOP_BITS=2, TX_EN dropped mid-frame with a word queued → current frame completes with 2 stop bit-times high. The next frame starts only after TX_EN returns high.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: parity modes,
// transmit FSM encoding and a frame-length helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Bit times in one frame: start + data + optional parity + stop bits.
  function automatic int frame_bits(input int data_w, input int parity, input int stop_bits);
    return 1 + data_w + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock write FIFO with separate occupancy counter, full/empty flags
// and a one-cycle overflow pulse for rejected writes.
module uart_sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  push, pop;

  // Occupancy never exceeds DEPTH, so its MSB alone marks a full FIFO.
  assign full     = count_q[DEPTH_LOG2];
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign rd_data  = mem_q[rd_ptr_q];

  always_comb begin
    push       = wr_en && !full;
    pop        = rd_en && !empty;
    wr_ptr_d   = wr_ptr_q + DEPTH_LOG2'(push);
    rd_ptr_d   = rd_ptr_q + DEPTH_LOG2'(pop);
    overflow_d = wr_en && full;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter with integrated baud divider and write FIFO; frames are
// sent back to back while words are queued and TX_EN is high.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int CLK_DIV    = 434,
  parameter int PARITY     = PARITY_NONE,
  parameter int STOP_BITS  = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                WR_EN,
  input  logic [DATA_W-1:0]   DATA,
  input  logic                TX_EN,
  output logic                TX,
  output logic                FULL,
  output logic                EMPTY,
  output logic [DEPTH_LOG2:0] COUNT,
  output logic                BUSY,
  output logic                OVERFLOW
);

  localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  tx_state_e          state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [3:0]         bit_q, bit_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               par_q, par_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               pop, load, bit_end, can_start, fifo_empty;
  logic [DATA_W-1:0]  fifo_data;

  uart_sync_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (RST),
    .wr_en    (WR_EN),
    .wr_data  (DATA),
    .rd_en    (pop),
    .rd_data  (fifo_data),
    .full     (FULL),
    .empty    (fifo_empty),
    .count    (COUNT),
    .overflow (OVERFLOW)
  );

  assign EMPTY = fifo_empty;
  assign TX    = tx_q;
  assign BUSY  = busy_q;

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    load      = 1'b0;
    bit_end   = (baud_q == BAUD_W'(CLK_DIV - 1));
    can_start = !fifo_empty && TX_EN;
    baud_d    = (state_q == ST_IDLE || bit_end) ? '0 : baud_q + BAUD_W'(1);

    case (state_q)
      ST_IDLE: load = can_start;
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == 4'(DATA_W - 1)) begin
            bit_d = '0;
            if (PARITY != PARITY_NONE) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_q == 4'(STOP_BITS - 1)) begin
            if (can_start) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Starting a frame, from idle or straight after a stop bit, pops the head word.
    if (load) begin
      pop     = 1'b1;
      state_d = ST_START;
      tx_d    = 1'b0;
      baud_d  = '0;
      shift_d = fifo_data;
      par_d   = (^fifo_data) ^ (PARITY == PARITY_ODD);
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

endmodule
